// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style control unit: Moore FSM with a programmable memory wait.
// Wait states hold for MEM_WAIT cycles using a shared 4-bit counter.
module controle_multiciclo #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemRW,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ULASrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       RESET,
  output logic       Excecao,
  output logic [1:0] PCSource,
  output logic [2:0] ULAOp,
  output logic [1:0] ULASrcB,
  output logic [4:0] estadoControle
);

  typedef enum logic [4:0] {
    RST         = 5'd0,
    BUSCA       = 5'd1,
    ESPERA      = 5'd2,
    DECODIFICA  = 5'd3,
    EXEC_R      = 5'd4,
    ESCRITA_R   = 5'd5,
    CALC_END    = 5'd6,
    LE_MEM      = 5'd7,
    ESCRITA_LW  = 5'd8,
    ESCREVE_MEM = 5'd9,
    BRANCH      = 5'd10,
    JUMP        = 5'd11,
    EXEC_I      = 5'd12,
    ESCRITA_I   = 5'd13,
    PARADO      = 5'd14,
    EXCECAO     = 5'd15
  } state_t;

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     next;
  logic [3:0] cnt;
  logic       in_wait;
  logic       wait_done;

  assign in_wait   = (state == ESPERA) || (state == LE_MEM) ||
                     (state == ESCREVE_MEM);
  assign wait_done = (cnt == LAST);

  // Counter restarts whenever the state changes, so every wait entry sees 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST;
      cnt   <= '0;
    end else begin
      state <= next;
      if (next != state || !in_wait) cnt <= '0;
      else                           cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      RST:        next = BUSCA;
      BUSCA:      next = ESPERA;
      ESPERA:     if (wait_done) next = DECODIFICA;
      DECODIFICA: begin
        unique case (Opcode)
          6'h00:        next = (Funct == 6'h0D) ? PARADO : EXEC_R;
          6'h02:        next = JUMP;
          6'h04, 6'h05: next = BRANCH;
          6'h08:        next = EXEC_I;
          6'h23, 6'h2B: next = CALC_END;
          default:      next = EXCECAO;
        endcase
      end
      EXEC_R:      next = ESCRITA_R;
      ESCRITA_R:   next = BUSCA;
      CALC_END:    next = (Opcode == 6'h23) ? LE_MEM : ESCREVE_MEM;
      LE_MEM:      if (wait_done) next = ESCRITA_LW;
      ESCRITA_LW:  next = BUSCA;
      ESCREVE_MEM: if (wait_done) next = BUSCA;
      BRANCH:      next = BUSCA;
      JUMP:        next = BUSCA;
      EXEC_I:      next = ESCRITA_I;
      ESCRITA_I:   next = BUSCA;
      PARADO:      next = PARADO;
      EXCECAO:     next = EXCECAO;
      default:     next = RST;
    endcase
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ULASrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    RESET       = 1'b0;
    Excecao     = 1'b0;
    PCSource    = 2'b00;
    ULAOp       = 3'b000;
    ULASrcB     = 2'b00;
    unique case (state)
      RST: RESET = 1'b1;
      BUSCA: begin
        MemRead = 1'b1;
        ULASrcB = 2'b01;
        PCWrite = 1'b1;
      end
      ESPERA: begin
        MemRead = 1'b1;
        IRWrite = wait_done;
      end
      DECODIFICA: ULASrcB = 2'b11;
      EXEC_R: begin
        ULASrcA = 1'b1;
        ULAOp   = 3'b010;
      end
      ESCRITA_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      CALC_END: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
      end
      LE_MEM: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ESCRITA_LW: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      ESCREVE_MEM: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        ULASrcA     = 1'b1;
        ULAOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = (Opcode == 6'h05);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      EXEC_I: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
      end
      ESCRITA_I: RegWrite = 1'b1;
      EXCECAO:   Excecao  = 1'b1;
      default: ;
    endcase
  end

  assign MemRW          = MemWrite;
  assign estadoControle = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench: three lanes (MEM_WAIT 1..3) run random instruction streams.
// Expected per-cycle outputs come from an instruction-level sequence model.
module tb_controle_multiciclo;

  typedef struct packed {
    logic [4:0] st;
    logic       pcwc, pcw, bne, iord, mrd, mwr, mrw, m2r;
    logic       irw, srca, rw, rdst, rst_o, exc;
    logic [1:0] pcs;
    logic [2:0] aluop;
    logic [1:0] srcb;
  } vec_t;

  localparam int NI = 40;

  logic       clk;
  logic       rst  [3];
  logic [5:0] op   [3];
  logic [5:0] fn   [3];
  vec_t       act  [3];
  vec_t       q    [3][$];
  bit         done [3];
  int         vectors;
  int         errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output values the control unit must show in a given state.
  function automatic vec_t mk(int s, bit last, bit ne);
    vec_t v;
    v = '0;
    v.st = 5'(s);
    case (s)
      0:  v.rst_o = 1'b1;
      1:  begin v.mrd = 1'b1; v.pcw = 1'b1; v.srcb = 2'b01; end
      2:  begin v.mrd = 1'b1; v.irw = last; end
      3:  v.srcb = 2'b11;
      4:  begin v.srca = 1'b1; v.aluop = 3'b010; end
      5:  begin v.rdst = 1'b1; v.rw = 1'b1; end
      6:  begin v.srca = 1'b1; v.srcb = 2'b10; end
      7:  begin v.iord = 1'b1; v.mrd = 1'b1; end
      8:  begin v.m2r = 1'b1; v.rw = 1'b1; end
      9:  begin v.iord = 1'b1; v.mwr = 1'b1; v.mrw = 1'b1; end
      10: begin
        v.srca = 1'b1; v.aluop = 3'b001;
        v.pcwc = 1'b1; v.pcs = 2'b01; v.bne = ne;
      end
      11: begin v.pcw = 1'b1; v.pcs = 2'b10; end
      12: begin v.srca = 1'b1; v.srcb = 2'b10; end
      13: v.rw = 1'b1;
      15: v.exc = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // Per-cycle trace of one instruction; cut stops after the first LE_MEM cycle.
  function automatic int build(int w, logic [5:0] o, logic [5:0] f,
                               bit cut, output vec_t s [32]);
    int n;
    n = 0;
    s[n] = mk(1, 0, 0); n++;
    for (int i = 0; i < w; i++) begin
      s[n] = mk(2, i == w - 1, 0); n++;
    end
    s[n] = mk(3, 0, 0); n++;
    case (o)
      6'h00: begin
        if (f == 6'h0D) begin
          for (int i = 0; i < 10; i++) begin s[n] = mk(14, 0, 0); n++; end
        end else begin
          s[n] = mk(4, 0, 0); n++;
          s[n] = mk(5, 0, 0); n++;
        end
      end
      6'h02: begin s[n] = mk(11, 0, 0); n++; end
      6'h04, 6'h05: begin s[n] = mk(10, 0, o == 6'h05); n++; end
      6'h08: begin
        s[n] = mk(12, 0, 0); n++;
        s[n] = mk(13, 0, 0); n++;
      end
      6'h23: begin
        s[n] = mk(6, 0, 0); n++;
        if (cut) begin
          s[n] = mk(7, 0, 0); n++;
        end else begin
          for (int i = 0; i < w; i++) begin s[n] = mk(7, 0, 0); n++; end
          s[n] = mk(8, 0, 0); n++;
        end
      end
      6'h2B: begin
        s[n] = mk(6, 0, 0); n++;
        for (int i = 0; i < w; i++) begin s[n] = mk(9, 0, 0); n++; end
      end
      default: begin
        for (int i = 0; i < 10; i++) begin s[n] = mk(15, 0, 0); n++; end
      end
    endcase
    return n;
  endfunction

  function automatic bit legal(logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = g + 1;
    logic pcwc, pcw, bne, iord, mrd, mwr, mrw, m2r;
    logic irw, srca, rw, rdst, rst_o, exc;
    logic [1:0] pcs;
    logic [2:0] aluop;
    logic [1:0] srcb;
    logic [4:0] st;

    controle_multiciclo #(.MEM_WAIT(W)) dut (
      .clk(clk), .reset(rst[g]), .Opcode(op[g]), .Funct(fn[g]),
      .PCWriteCond(pcwc), .PCWrite(pcw), .BranchNe(bne), .IorD(iord),
      .MemRead(mrd), .MemWrite(mwr), .MemRW(mrw), .MemtoReg(m2r),
      .IRWrite(irw), .ULASrcA(srca), .RegWrite(rw), .RegDst(rdst),
      .RESET(rst_o), .Excecao(exc), .PCSource(pcs), .ULAOp(aluop),
      .ULASrcB(srcb), .estadoControle(st)
    );

    assign act[g] = {st, pcwc, pcw, bne, iord, mrd, mwr, mrw, m2r,
                     irw, srca, rw, rdst, rst_o, exc, pcs, aluop, srcb};

    initial begin
      vec_t s [32];
      int   n;
      int   kind;
      bit   cut;
      bit   stop;
      logic [5:0] o;
      logic [5:0] f;
      done[g] = 1'b0;
      rst[g]  = 1'b1;
      op[g]   = 6'h00;
      fn[g]   = 6'h00;
      @(posedge clk); #1;
      q[g].push_back(mk(0, 0, 0));
      @(posedge clk); #1;
      rst[g] = 1'b0;
      q[g].push_back(mk(0, 0, 0));
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        kind = (k == 0) ? 0 : (k == 1) ? 8 : (k == 2) ? 9 :
               int'($urandom_range(0, 11));
        cut = 1'b0;
        f = 6'($urandom_range(0, 63));
        case (kind)
          0, 10: begin o = 6'h00; if (f == 6'h0D) f = 6'h20; end
          1:     begin o = 6'h00; f = 6'h0D; end
          2:     o = 6'h02;
          3:     o = 6'h04;
          4:     o = 6'h05;
          5:     o = 6'h08;
          6, 11: o = 6'h23;
          7:     o = 6'h2B;
          9:     begin o = 6'h23; cut = 1'b1; end
          default: begin
            o = (k == 1) ? 6'h3F : 6'($urandom_range(0, 63));
            while (legal(o)) o = 6'($urandom_range(0, 63));
          end
        endcase
        if (k == 0) f = 6'h20;
        stop = cut || !legal(o) || (o == 6'h00 && f == 6'h0D);
        op[g] = o;
        fn[g] = f;
        n = build(W, o, f, cut, s);
        for (int i = 0; i < n; i++) q[g].push_back(s[i]);
        repeat (n) @(posedge clk);
        #1;
        if (stop) begin
          // Reset lands mid-cycle; the next negedge sees RST with no clock edge.
          rst[g] = 1'b1;
          q[g].push_back(mk(0, 0, 0));
          @(posedge clk); #1;
          rst[g] = 1'b0;
          q[g].push_back(mk(0, 0, 0));
          @(posedge clk); #1;
        end
      end
      @(negedge clk);
      #1;
      done[g] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (q[l].size() > 0) begin
        vec_t e;
        e = q[l].pop_front();
        vectors++;
        if (act[l] !== e) begin
          errors++;
          $display("FAIL wait%0d st%0d: got %h required %h",
                   l + 1, e.st, act[l], e);
        end
      end
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    wait (done[0] && done[1] && done[2]);
    for (int l = 0; l < 3; l++) begin
      vectors++;
      if (q[l].size() != 0) begin
        errors++;
        $display("FAIL drain%0d: got %0d pending required 0",
                 l + 1, q[l].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
